rv32_inst_encoder: RTL and testbench
====================================

Name: rv32_inst_encoder

Overview:
- Inverse of the instruction decoder: takes decoded RV32I fields (format, opcode, funct3, funct7, rs1, rs2, rd, imm) and packs them into a 32-bit instruction word.
- Emits each word with a sequential byte address for loading instruction memory, such as a testbench or boot program loader feeding the NPC.
- Valid/ready on both sides; one registered output stage.
- Validates immediates per format. Illegal requests are dropped and counted.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of the first emitted word.
- DEPTH, 1024, maximum words emitted before the block reports full (power of two not required).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- clear  input  1  synchronous restart: zeroes word count, returns address to BASE_ADDR, clears err flag
- in_valid  input  1  field bundle valid
- in_ready  output  1  bundle accepted when in_valid&in_ready
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- in_opcode  input  7  inst[6:0]
- in_funct3  input  3  inst[14:12] (R/I/S/B)
- in_funct7  input  7  inst[31:25] (R only)
- in_rs1  input  5  source reg 1
- in_rs2  input  5  source reg 2
- in_rd  input  5  destination reg
- in_imm  input  32  sign-extended immediate value (full byte offset for B/J; full value for U)
- out_valid  output  1  word valid
- out_ready  input  1  consumer ready
- out_inst  output  32  encoded instruction
- out_addr  output  32  byte address of out_inst
- full  output  1  DEPTH words emitted
- err  output  1  sticky: at least one request dropped
- err_cnt  output  16  dropped-request count, saturating at 16'hFFFF

Behaviour:
- Reset values: out_valid=0, out_inst=0, out_addr=BASE_ADDR, full=0, err=0, err_cnt=0, internal word count=0. in_ready is combinational.
- in_ready = !full && (!out_valid || out_ready). Accepting a bundle in the same cycle the held word drains is required (full throughput, 1 word/cycle).
- Latency: an accepted legal bundle appears on out_inst with out_valid=1 the next cycle.
- out_inst/out_addr are held stable while out_valid && !out_ready.
- Encoding:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - Fields not used by a format are ignored.
- Legality:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - fmt 6/7: illegal.
  - in_opcode[1:0] != 2'b11: illegal.
- Illegal accepted bundle: consumed (handshake completes), no output word, address not advanced, err<=1, err_cnt+1 (saturating).
- Address/count:
  - out_addr for a word = BASE_ADDR + 4*(its index).
  - The count increments on each legal accept.
  - full asserts the cycle after the DEPTH-th legal accept. Further in_valid is stalled; the last word still drains normally.
- clear has priority over any accept in the same cycle: the bundle is not accepted (in_ready forced 0 that cycle), out_valid<=0, any pending word is discarded, count/addr/full/err/err_cnt reset.
- rst mid-transfer: identical to the reset values; the pending word is lost.
- Address arithmetic wraps modulo 2^32 with no flag.

Decomposition:
- Shared package rv32_pkg, also used by the decoder:
  - format codes FMT_R..FMT_J
  - opcode constants (OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM, OP_REG, ...)
  - immediate range constants
- One natural sub-module: rv32_imm_pack. Purely combinational: fmt + fields + imm to inst[31:0] plus legal flag. Shared with the bench as a reference model.
- The top holds the handshake register, counter and error logic.

Test Plan:
- Legal single words, BASE_ADDR default, out_ready=1:
  - I addi x1,x0,5 -> 32'h00500093 @ 8000_0000
  - R add x3,x1,x2 (f7=0) -> 32'h002081B3 @ 8000_0004
  - S sw x2,8(x1) -> 32'h0020A423
  - B beq x1,x2,-4 -> 32'hFE208EE3
  - J jal x1,8 -> 32'h008000EF
  - U lui x5,0x12345000 -> 32'h123452B7
- Backpressure: stream 4 words, out_ready low for 3 cycles -> out_inst/out_addr stable, in_ready=0, no word lost or duplicated. Back-to-back with out_ready=1 -> one word per cycle.
- Illegal requests, each dropped with no out_valid and the next legal word at an unchanged address; err=1, err_cnt=4:
  - I imm=2048
  - B imm=3
  - U imm=0x1001
  - fmt=6
- DEPTH=4: 5 legal bundles -> 4 words at 8000_0000..8000_000C; full=1; 5th held with in_ready=0.
- Apply clear -> full=0; the 5th accepted at 8000_0000.
- clear asserted with in_valid=1 and a pending word -> bundle not accepted, out_valid=0 next cycle, err_cnt=0.
- rst asserted mid-stream -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I definitions used by the encoder and the decoder.
//   - instruction format codes (FMT_R..FMT_J)
//   - major opcode constants
//   - signed immediate range limits for the I/S, B and J formats
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Inclusive signed ranges of the encodable immediates.
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

endpackage

// File: rtl/rv32_imm_pack.sv
// rv32_imm_pack: purely combinational RV32I field packer.
// Ports:
//   fmt      format code (FMT_R..FMT_J, 6/7 illegal)
//   opcode, funct3, funct7, rs1, rs2, rd   raw instruction fields
//   imm      sign-extended immediate (byte offset for B/J, full value for U)
//   inst     packed 32-bit instruction word
//   legal    1 when the immediate fits the format and the opcode is 32-bit
module rv32_imm_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        legal
);

  logic signed [31:0] simm;
  assign simm = $signed(imm);

  always_comb begin
    inst  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        inst  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        inst  = {imm[11:0], rs1, funct3, rd, opcode};
        legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      FMT_S: begin
        inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      FMT_B: begin
        inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = (simm >= IMMB_MIN) && (simm <= IMMB_MAX) && !imm[0];
      end
      FMT_U: begin
        inst  = {imm[31:12], rd, opcode};
        legal = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = (simm >= IMMJ_MIN) && (simm <= IMMJ_MAX) && !imm[0];
      end
      default: begin
        inst  = '0;
        legal = 1'b0;
      end
    endcase
    // Compressed-encoding opcodes cannot be produced by this encoder.
    if (opcode[1:0] != 2'b11) legal = 1'b0;
  end

endmodule

// File: rtl/rv32_inst_encoder.sv
// rv32_inst_encoder: packs decoded RV32I field bundles into instruction
// words and tags each with a sequential byte address for loading memory.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clear            synchronous restart of count/address/error state
//   in_valid/in_ready + in_fmt..in_imm    field bundle input
//   out_valid/out_ready + out_inst/out_addr   registered word output
//   full             DEPTH words emitted, input stalled
//   err, err_cnt     sticky drop flag and saturating drop count
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable while valid && !ready; ready may
// depend combinationally on the consumer's ready (in_ready follows
// out_ready so a new bundle can enter while the held word drains).
module rv32_inst_encoder
  import rv32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        full,
  output logic        err,
  output logic [15:0] err_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic [31:0]   next_addr;  // address the next legal word will receive
  logic [31:0]   packed_inst;
  logic          legal;
  logic          accept;

  rv32_imm_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .rd     (in_rd),
    .imm    (in_imm),
    .inst   (packed_inst),
    .legal  (legal)
  );

  assign full     = (count == CW'(DEPTH));
  // clear blocks acceptance so a bundle is never half-taken during restart.
  assign in_ready = !clear && !full && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= BASE_ADDR;
      next_addr <= BASE_ADDR;
      count     <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_inst  <= packed_inst;
        out_addr  <= next_addr;
        next_addr <= next_addr + 32'd4;
        count     <= count + CW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Dropped bundles still complete their handshake.
      if (accept && !legal) begin
        err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Directed bench for rv32_inst_encoder (DEPTH=4 so the full boundary is
// reached quickly; clear separates the phases).
module tb_rv32_inst_encoder;
  import rv32_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, in_valid, in_ready, out_valid, out_ready, full, err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm, out_inst, out_addr;
  logic [15:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  rv32_inst_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .full      (full),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdd, input logic [31:0] im);
    in_fmt    = f;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rs1    = r1;
    in_rs2    = r2;
    in_rd     = rdd;
    in_imm    = im;
    in_valid  = 1'b1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rdd, input logic [31:0] im);
    drive(f, op, f3, f7, r1, r2, rdd, im);
    step();
    in_valid = 1'b0;
  endtask

  task automatic addi(input logic [31:0] im);
    send(FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, im);
  endtask

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] inst, input logic [31:0] addr);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_addr"}, out_addr, addr);
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_inst"}, out_inst, 32'd0);
    check({tag, "_addr"}, out_addr, BASE);
    check({tag, "_full"}, {31'd0, full}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_errcnt"}, {16'd0, err_cnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    step(); step();
    rst = 1'b0;
    #1;
    expect_reset("rst");
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // legal words, one per format, filling DEPTH=4
    addi(32'd5);
    expect_word("addi", 32'h0050_0093, BASE);
    send(FMT_R, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    expect_word("add", 32'h0020_81B3, BASE + 32'd4);
    send(FMT_S, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    expect_word("sw", 32'h0020_A423, BASE + 32'd8);
    send(FMT_B, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);
    expect_word("beq", 32'hFE20_8EE3, BASE + 32'd12);
    check("full_set", {31'd0, full}, 32'd1);

    // fifth bundle held while full; last word drains normally
    drive(FMT_J, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8);
    #1;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("full_drained", {31'd0, out_valid}, 32'd0);
    check("full_still", {31'd0, full}, 32'd1);
    clear = 1'b1;
    #1;
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    clear = 1'b0;
    #1;
    check("clear_full", {31'd0, full}, 32'd0);
    check("clear_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    expect_word("jal", 32'h0080_00EF, BASE);
    send(FMT_U, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
    expect_word("lui", 32'h1234_52B7, BASE + 32'd4);

    // illegal requests are dropped without advancing the address
    clear = 1'b1; step(); clear = 1'b0;
    addi(32'd5);
    expect_word("pre_ill", 32'h0050_0093, BASE);
    addi(32'd2048);
    check("ill_i_valid", {31'd0, out_valid}, 32'd0);
    check("ill_i_err", {31'd0, err}, 32'd1);
    check("ill_i_cnt", {16'd0, err_cnt}, 32'd1);
    send(FMT_B, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
    check("ill_b_valid", {31'd0, out_valid}, 32'd0);
    check("ill_b_cnt", {16'd0, err_cnt}, 32'd2);
    send(FMT_U, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h0000_1001);
    check("ill_u_valid", {31'd0, out_valid}, 32'd0);
    check("ill_u_cnt", {16'd0, err_cnt}, 32'd3);
    send(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    check("ill_f6_valid", {31'd0, out_valid}, 32'd0);
    check("ill_f6_cnt", {16'd0, err_cnt}, 32'd4);
    addi(32'd2047);
    expect_word("i_max", 32'h7FF0_0093, BASE + 32'd4);
    send(FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094);
    expect_word("b_max", 32'h7E00_0FE3, BASE + 32'd8);
    check("ill_err_hold", {31'd0, err}, 32'd1);
    check("ill_cnt_hold", {16'd0, err_cnt}, 32'd4);

    // backpressure: held word stable, input stalled, then one word per cycle
    clear = 1'b1; step(); clear = 1'b0;
    #1;
    check("bp_err_clr", {31'd0, err}, 32'd0);
    check("bp_cnt_clr", {16'd0, err_cnt}, 32'd0);
    out_ready = 1'b0;
    addi(32'd1);
    expect_word("bp_w0", 32'h0010_0093, BASE);
    drive(FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
      expect_word("bp_hold", 32'h0010_0093, BASE);
      step();
    end
    out_ready = 1'b1;
    step();
    expect_word("bp_w1", 32'h0020_0093, BASE + 32'd4);
    drive(FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd3);
    step();
    expect_word("bp_w2", 32'h0030_0093, BASE + 32'd8);
    drive(FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd4);
    step();
    in_valid = 1'b0;
    expect_word("bp_w3", 32'h0040_0093, BASE + 32'd12);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_full", {31'd0, full}, 32'd1);

    // clear with a pending word and a waiting bundle
    clear = 1'b1; step(); clear = 1'b0;
    send(3'd7, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    check("cp_err_pre", {16'd0, err_cnt}, 32'd1);
    out_ready = 1'b0;
    addi(32'd1);
    expect_word("cp_pend", 32'h0010_0093, BASE);
    drive(FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2);
    out_ready = 1'b1;
    clear = 1'b1;
    #1;
    check("cp_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    check("cp_valid", {31'd0, out_valid}, 32'd0);
    check("cp_errcnt", {16'd0, err_cnt}, 32'd0);
    check("cp_err", {31'd0, err}, 32'd0);
    step();
    check("cp_not_taken", {31'd0, out_valid}, 32'd0);
    addi(32'd3);
    expect_word("cp_after", 32'h0030_0093, BASE);

    // reset mid-stream
    send(3'd6, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    addi(32'd1);
    addi(32'd2);
    expect_word("rm_pre", 32'h0020_0093, BASE + 32'd8);
    drive(FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    expect_reset("rm");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
